egress_qos_scheduler: RTL and testbench
=======================================

EGRESS_QOS_SCHEDULER -- requirements
Module: egress_qos_scheduler

Interface
REQ-001 SHALL have parameter PORT_NUM, default 16: number of source VOQs feeding this output port; 2..32.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload word width.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 4: width of each WRR weight.
REQ-004 SHALL have parameter MAX_PKT_LEN, default 256: maximum legal packet length in words.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port empty, input, PORT_NUM: bit s high means VOQ s holds no word for this output.
REQ-008 SHALL have port eop_head, input, PORT_NUM: bit s is the eop flag of the head word of VOQ s; valid only while empty[s] is low.
REQ-009 SHALL have port data_in, input, DATA_WIDTH: VOQ read data; valid exactly 1 cycle after rd_en.
REQ-010 SHALL have port rd_en, output, 1: pop the head word of VOQ rd_sel.
REQ-011 SHALL have port rd_sel, output, $clog2(PORT_NUM): index of the granted VOQ.
REQ-012 SHALL have port qos_mode, input, 2: 0 = round robin, 1 = strict priority, 2 = weighted round robin, 3 = treated as 0.
REQ-013 SHALL have port weight, input, PORT_NUM*WEIGHT_WIDTH: WRR weight of source s in bits [s*WEIGHT_WIDTH +: WEIGHT_WIDTH].
REQ-014 SHALL have ports rd_vld, rd_sop and rd_eop, each output, 1: output word valid, first word of a packet and last word of a packet.
REQ-015 SHALL have port rd_data, output, DATA_WIDTH: output word.
REQ-016 SHALL have port ready, input, 1: downstream accepts a word when rd_vld && ready.
REQ-017 SHALL have port error, output, 1: one-cycle pulse on a packet-length violation.
REQ-018 SHALL have port busy, output, 1: high while a packet grant is held.

Function
REQ-019 SHALL implement an FSM with states IDLE and XFER.
REQ-020 In IDLE, when any empty bit is low, SHALL select a source per the mode latched that cycle, register it on rd_sel and enter XFER on the next edge; SHALL not assert rd_en in IDLE.
REQ-021 Mode 0: SHALL grant the first non-empty source at or after rr_ptr+1 (modulo PORT_NUM); rr_ptr SHALL update to the granted index.
REQ-022 Mode 1: SHALL grant the lowest-index non-empty source.
REQ-023 Mode 2: each source SHALL keep a credit counter; SHALL use RR order among non-empty sources with credit>0 and decrement that credit by 1 per granted packet.
REQ-024 Mode 2: when no non-empty source has credit>0, SHALL reload every credit from weight, treating weight 0 as 1, and arbitrate in that same cycle.
REQ-025 qos_mode and weight SHALL only be sampled in IDLE; a change mid-packet SHALL not affect the current packet.
REQ-026 SHALL keep a 2-entry output skid buffer; rd_en SHALL be asserted in XFER only when !empty[rd_sel] and (occupancy + in-flight reads) < 2.
REQ-027 Latency: rd_en at cycle t SHALL make the word present at rd_data, with rd_vld high, from cycle t+1 if the buffer was empty; sustained throughput SHALL be 1 word/cycle while ready is high.
REQ-028 The first word popped after a grant SHALL carry rd_sop=1; the word popped while eop_head[rd_sel]=1 SHALL carry rd_eop=1.
REQ-029 After the rd_en on an eop word, SHALL return to IDLE on the next edge; busy SHALL drop at the same time.
REQ-030 A single-word packet (sop=eop) SHALL be legal.
REQ-031 An empty VOQ mid-packet SHALL stall rd_en without error and without releasing the grant.
REQ-032 SHALL count words per packet; if word MAX_PKT_LEN is popped without eop, that word SHALL carry forced rd_eop=1, error SHALL pulse in the following cycle, and the FSM SHALL return to IDLE.
REQ-033 rd_vld, rd_data, rd_sop and rd_eop SHALL hold stable while rd_vld && !ready.
REQ-034 Skid buffer full with ready low: rd_en SHALL stay low; no word SHALL be lost or duplicated.

Reset
REQ-035 On rst SHALL asynchronously force: state IDLE, rd_en=0, rd_sel=0, rr_ptr=PORT_NUM-1, all credits 0, skid buffer emptied, rd_vld=rd_sop=rd_eop=0, rd_data=0, error=0, busy=0.
REQ-036 Reset mid-packet SHALL discard in-flight data; after reset the first packet SHALL start with rd_sop=1.

Verification
REQ-037 Mode 0, VOQs 0, 3 and 5 each hold one 4-word packet, ready=1 -> packets emitted in order 0, 3, 5; each shows rd_sop on word 1 and rd_eop on word 4; no idle cycles within a packet.
REQ-038 Mode 1, VOQs 2 and 7 continuously backlogged -> only source 2 is granted.
REQ-039 Mode 2, weights s0=3, s1=1, both backlogged with 1-word packets -> grant pattern 0,0,0,1 repeats.
REQ-040 ready toggles 1-0-1 every cycle during a 10-word packet -> all 10 words delivered once, in order, stable while stalled; rd_en never exceeds buffer space.
REQ-041 MAX_PKT_LEN=8, 12-word packet with no eop until word 12 -> word 8 carries rd_eop; error pulses 1 cycle; the next grant starts with rd_sop.
REQ-042 rst asserted at word 3 of a 6-word packet -> all outputs reach reset values immediately, with no rd_vld until a new grant.

Source files
------------

// File: rtl/egress_qos_scheduler.sv
// Egress scheduler for one output port: arbitrates PORT_NUM VOQs (RR / strict / WRR),
// holds the grant for a whole packet and feeds a 2-entry skid buffer toward downstream.
module egress_qos_scheduler #(
  parameter int PORT_NUM     = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int WEIGHT_WIDTH = 4,
  parameter int MAX_PKT_LEN  = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORT_NUM-1:0]              empty,
  input  logic [PORT_NUM-1:0]              eop_head,
  input  logic [DATA_WIDTH-1:0]            data_in,
  output logic                             rd_en,
  output logic [$clog2(PORT_NUM)-1:0]      rd_sel,
  input  logic [1:0]                       qos_mode,
  input  logic [PORT_NUM*WEIGHT_WIDTH-1:0] weight,
  output logic                             rd_vld,
  output logic                             rd_sop,
  output logic                             rd_eop,
  output logic [DATA_WIDTH-1:0]            rd_data,
  input  logic                             ready,
  output logic                             error,
  output logic                             busy
);
  localparam int SEL_W = $clog2(PORT_NUM);
  localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_PKT_LEN - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]              state;
  logic [SEL_W-1:0]        rr_ptr;
  logic [CNT_W-1:0]        word_cnt;
  logic [WEIGHT_WIDTH-1:0] credit     [PORT_NUM];
  logic [WEIGHT_WIDTH-1:0] credit_nxt [PORT_NUM];
  logic [PORT_NUM-1:0]     req, elig, mask, grant_oh;
  logic                    reload, grant_vld;
  logic [SEL_W-1:0]        grant_idx, scan_idx;
  int unsigned             start;
  logic                    force_eop, word_eop;

  // WRR scans from rr_ptr so a source keeps winning while it has credit;
  // after a reload the scan moves past it, giving a w0,w0,..,w1 burst pattern.
  always_comb begin
    req       = ~empty;
    reload    = 1'b0;
    mask      = req;
    start     = 32'(rr_ptr) + 32'd1;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    scan_idx  = '0;
    for (int unsigned s = 0; s < PORT_NUM; s++) elig[s] = req[s] && (credit[s] != '0);
    case (qos_mode)
      2'd1: start = 32'd0;
      2'd2: begin
        reload = (elig == '0);
        if (!reload) begin
          mask  = elig;
          start = 32'(rr_ptr);
        end
      end
      default: ;
    endcase
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      scan_idx = SEL_W'((start + i) % PORT_NUM);
      if (!grant_vld && mask[scan_idx]) begin
        grant_vld          = 1'b1;
        grant_idx          = scan_idx;
        grant_oh[scan_idx] = 1'b1;
      end
    end
    for (int unsigned s = 0; s < PORT_NUM; s++) begin
      credit_nxt[s] = credit[s];
      if (reload) begin
        if (weight[s*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0) credit_nxt[s] = WEIGHT_WIDTH'(1);
        else credit_nxt[s] = weight[s*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
      credit_nxt[s] = credit_nxt[s] - WEIGHT_WIDTH'(grant_oh[s]);
    end
  end

  logic       in_vld, in_sop, in_eop;
  logic [1:0] occ;
  logic       head, tail;
  logic       accept, push, pop;
  logic [DATA_WIDTH+1:0] skid [2];
  logic [DATA_WIDTH+1:0] out_word;

  assign force_eop = (word_cnt == LAST_IDX);
  assign word_eop  = eop_head[rd_sel] || force_eop;
  assign rd_en     = (state == XFER) && !empty[rd_sel] && ((3'(occ) + 3'(in_vld)) < 3'd2);
  assign busy      = (state == XFER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_sel   <= '0;
      rr_ptr   <= SEL_W'(PORT_NUM - 1);
      word_cnt <= '0;
      error    <= 1'b0;
      for (int unsigned s = 0; s < PORT_NUM; s++) credit[s] <= '0;
    end else begin
      error <= rd_en && force_eop && !eop_head[rd_sel];
      case (state)
        IDLE: begin
          if (grant_vld) begin
            state    <= XFER;
            rd_sel   <= grant_idx;
            word_cnt <= '0;
            if (qos_mode != 2'd1) rr_ptr <= grant_idx;
            if (qos_mode == 2'd2) credit <= credit_nxt;
          end
        end
        default: begin
          if (rd_en) begin
            word_cnt <= word_cnt + CNT_W'(1);
            if (word_eop) state <= IDLE;
          end
        end
      endcase
    end
  end

  // Word arriving from the VOQ bypasses the skid buffer when it is empty.
  always_comb begin
    rd_vld = (occ != 2'd0) || in_vld;
    if (occ != 2'd0) out_word = skid[head];
    else if (in_vld) out_word = {in_sop, in_eop, data_in};
    else             out_word = '0;
    {rd_sop, rd_eop, rd_data} = out_word;
    accept = rd_vld && ready;
    push   = in_vld && !((occ == 2'd0) && accept);
    pop    = accept && (occ != 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_vld <= 1'b0;
      in_sop <= 1'b0;
      in_eop <= 1'b0;
      occ    <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
    end else begin
      in_vld <= rd_en;
      in_sop <= rd_en && (word_cnt == '0);
      in_eop <= rd_en && word_eop;
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) skid[tail] <= {in_sop, in_eop, data_in};
  end

endmodule

// File: tb/tb_egress_qos_scheduler.sv
// Scoreboard bench for egress_qos_scheduler; a second instance with MAX_PKT_LEN=8
// covers the length-violation path and is held in reset while unused.
module tb_egress_qos_scheduler;
  localparam int PN = 16;
  localparam int DW = 32;
  localparam int WW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst  = 1'b1;
  logic           use8 = 1'b0;
  logic [PN-1:0]  empty = '1;
  logic [PN-1:0]  eop_head = '0;
  logic [DW-1:0]  data_in = '0;
  logic [1:0]     qos_mode = 2'd0;
  logic [PN*WW-1:0] weight = '0;
  logic           ready = 1'b1;

  logic a_rd_en, a_rd_vld, a_rd_sop, a_rd_eop, a_error, a_busy;
  logic b_rd_en, b_rd_vld, b_rd_sop, b_rd_eop, b_error, b_busy;
  logic [3:0]    a_rd_sel, b_rd_sel;
  logic [DW-1:0] a_rd_data, b_rd_data;
  logic rst_a, rst_b;

  logic rd_en, rd_vld, rd_sop, rd_eop, error, busy;
  logic [3:0]    rd_sel;
  logic [DW-1:0] rd_data;

  assign rst_a   = rst | use8;
  assign rst_b   = rst | ~use8;
  assign rd_en   = use8 ? b_rd_en   : a_rd_en;
  assign rd_sel  = use8 ? b_rd_sel  : a_rd_sel;
  assign rd_vld  = use8 ? b_rd_vld  : a_rd_vld;
  assign rd_sop  = use8 ? b_rd_sop  : a_rd_sop;
  assign rd_eop  = use8 ? b_rd_eop  : a_rd_eop;
  assign rd_data = use8 ? b_rd_data : a_rd_data;
  assign error   = use8 ? b_error   : a_error;
  assign busy    = use8 ? b_busy    : a_busy;

  egress_qos_scheduler #(.PORT_NUM(PN), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .MAX_PKT_LEN(256)) dut (
    .clk(clk), .rst(rst_a), .empty(empty), .eop_head(eop_head), .data_in(data_in),
    .rd_en(a_rd_en), .rd_sel(a_rd_sel), .qos_mode(qos_mode), .weight(weight),
    .rd_vld(a_rd_vld), .rd_sop(a_rd_sop), .rd_eop(a_rd_eop), .rd_data(a_rd_data),
    .ready(ready), .error(a_error), .busy(a_busy));

  egress_qos_scheduler #(.PORT_NUM(PN), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .MAX_PKT_LEN(8)) dut8 (
    .clk(clk), .rst(rst_b), .empty(empty), .eop_head(eop_head), .data_in(data_in),
    .rd_en(b_rd_en), .rd_sel(b_rd_sel), .qos_mode(qos_mode), .weight(weight),
    .rd_vld(b_rd_vld), .rd_sop(b_rd_sop), .rd_eop(b_rd_eop), .rd_data(b_rd_data),
    .ready(ready), .error(b_error), .busy(b_busy));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
    end
  endtask

  // VOQ model: entries are {eop, data}; expected stream entries are {sop, eop, data}.
  logic [DW:0]   voq [PN][$];
  logic [DW+1:0] exp_q [$];

  function automatic logic [DW-1:0] mk(input int src, input int tag, input int w);
    return {8'(src), 8'(tag), 16'(w)};
  endfunction

  task automatic voq_pkt(input int src, input int tag, input int len);
    for (int w = 1; w <= len; w++) voq[src].push_back({(w == len), mk(src, tag, w)});
  endtask

  task automatic exp_words(input int src, input int tag, input int first, input int last);
    for (int w = first; w <= last; w++) exp_q.push_back({(w == first), (w == last), mk(src, tag, w)});
  endtask

  logic       pop_pend = 1'b0;
  logic [3:0] pop_sel  = '0;

  always @(posedge clk) begin
    logic [DW:0] w;
    #1;
    if (pop_pend) begin
      check("pop_nonempty", voq[pop_sel].size() != 0, 1);
      if (voq[pop_sel].size() != 0) begin
        w = voq[pop_sel].pop_front();
        data_in = w[DW-1:0];
      end
    end
    for (int s = 0; s < PN; s++) begin
      empty[s]    = (voq[s].size() == 0);
      eop_head[s] = empty[s] ? 1'b0 : voq[s][0][DW];
    end
  end

  int            popped = 0, accepted = 0, err_cnt = 0;
  logic          stall_prev = 1'b0, in_pkt = 1'b0, err_prev = 1'b0, gap_chk = 1'b0;
  logic [DW+1:0] prev_word = '0;

  always @(negedge clk) begin
    if (rst) begin
      popped = 0; accepted = 0; pop_pend = 1'b0;
      stall_prev = 1'b0; in_pkt = 1'b0; err_prev = 1'b0;
    end else begin
      pop_pend = rd_en;
      pop_sel  = rd_sel;
      if (rd_en) check("buf_space", (popped - accepted) < 2, 1);
      if (stall_prev) begin
        check("hold_vld", rd_vld, 1);
        check("hold_word", {rd_sop, rd_eop, rd_data}, prev_word);
      end
      if (gap_chk && in_pkt && ready) check("no_gap", rd_vld, 1);
      if (error) begin
        err_cnt++;
        check("error_width", err_prev, 0);
      end
      err_prev = error;
      if (rd_vld && ready) begin
        check("sb_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("word", {rd_sop, rd_eop, rd_data}, exp_q.pop_front());
        in_pkt = !rd_eop;
        accepted++;
      end
      if (rd_en) popped++;
      stall_prev = rd_vld && !ready;
      prev_word  = {rd_sop, rd_eop, rd_data};
    end
  end

  task automatic check_reset_state(input string pfx);
    check({pfx, "_rd_vld"},  rd_vld,  0);
    check({pfx, "_rd_sop"},  rd_sop,  0);
    check({pfx, "_rd_eop"},  rd_eop,  0);
    check({pfx, "_rd_data"}, rd_data, 0);
    check({pfx, "_busy"},    busy,    0);
    check({pfx, "_error"},   error,   0);
    check({pfx, "_rd_en"},   rd_en,   0);
    check({pfx, "_rd_sel"},  rd_sel,  0);
  endtask

  task automatic flush();
    exp_q.delete();
    for (int s = 0; s < PN; s++) voq[s].delete();
  endtask

  task automatic do_reset(input logic sel8);
    rst = 1'b1; use8 = sel8; ready = 1'b1;
    flush();
    repeat (3) @(posedge clk);
    #2 check_reset_state("rst");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic drain(input int max_cyc, input logic toggle);
    int n = 0;
    int left = 0;
    while ((exp_q.size() != 0 || busy || rd_vld) && n < max_cyc) begin
      @(posedge clk);
      #2 if (toggle) ready = ~ready;
      n++;
    end
    ready = 1'b1;
    check("drain_in_time", n < max_cyc, 1);
    for (int s = 0; s < PN; s++) left += voq[s].size();
    check("voq_drained", left, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int err_base;
    int n;
    do_reset(1'b0);
    err_base = err_cnt;

    // Round robin from reset pointer: 0, 3, 5, back-to-back words.
    qos_mode = 2'd0;
    voq_pkt(0, 1, 4); voq_pkt(3, 2, 4); voq_pkt(5, 3, 4);
    exp_words(0, 1, 1, 4); exp_words(3, 2, 1, 4); exp_words(5, 3, 1, 4);
    gap_chk = 1'b1;
    drain(200, 1'b0);
    gap_chk = 1'b0;

    // Strict priority: source 2 fully drained before source 7.
    qos_mode = 2'd1;
    for (int p = 0; p < 5; p++) begin
      voq_pkt(7, 20 + p, 2);
      voq_pkt(2, 10 + p, 2);
    end
    for (int p = 0; p < 5; p++) exp_words(2, 10 + p, 1, 2);
    for (int p = 0; p < 5; p++) exp_words(7, 20 + p, 1, 2);
    drain(300, 1'b0);

    // WRR 3:1 with single-word packets.
    do_reset(1'b0);
    qos_mode = 2'd2;
    weight = '0;
    weight[0 +: WW] = 4'd3;
    weight[WW +: WW] = 4'd1;
    for (int p = 0; p < 9; p++) voq_pkt(0, 40 + p, 1);
    for (int p = 0; p < 3; p++) voq_pkt(1, 60 + p, 1);
    for (int g = 0; g < 3; g++) begin
      for (int k = 0; k < 3; k++) exp_words(0, 40 + g * 3 + k, 1, 1);
      exp_words(1, 60 + g, 1, 1);
    end
    drain(300, 1'b0);

    // Backpressure: ready toggles every cycle through a 10-word packet.
    qos_mode = 2'd0;
    voq_pkt(1, 70, 10);
    exp_words(1, 70, 1, 10);
    drain(300, 1'b1);
    check("no_error_so_far", err_cnt - err_base, 0);

    // Length violation on the MAX_PKT_LEN=8 instance.
    do_reset(1'b1);
    qos_mode = 2'd0;
    err_base = err_cnt;
    voq_pkt(4, 80, 12);
    exp_words(4, 80, 1, 8);
    exp_words(4, 80, 9, 12);
    drain(300, 1'b0);
    check("error_pulses", err_cnt - err_base, 1);

    // Reset in the middle of a 6-word packet.
    do_reset(1'b0);
    qos_mode = 2'd0;
    voq_pkt(6, 90, 6);
    exp_words(6, 90, 1, 6);
    n = 0;
    while (accepted < 2 && n < 100) begin
      @(posedge clk);
      #2 n++;
    end
    check("reach_word3", n < 100, 1);
    check("word3_visible", rd_vld, 1);
    rst = 1'b1;
    #1 check_reset_state("midpkt");
    flush();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("no_vld_after_rst", rd_vld, 0);
    end
    voq_pkt(6, 91, 2);
    exp_words(6, 91, 1, 2);
    drain(100, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
